// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types, defaults and DDR pattern helper for clkgen_divmux
//
// Purpose: channel FSM encoding, default geometry of the generator and the
// function that turns a counter phase into the {D1,D0} pair for ODDR2.
// Ports: none (package).
package clkgen_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } chan_state_t;

    localparam int NCH_DEF       = 4;
    localparam int DW_DEF        = 4;
    localparam int RESET_DIV_DEF = 1;

    // Widest divider field supported by ddr_pattern; channels zero-extend
    // into CMP_W so that 2*cnt+1 and R = DIV+1 never overflow.
    localparam int DW_MAX = 16;
    localparam int CMP_W  = DW_MAX + 2;

    // Returns {D1, D0} for counter phase cnt of a period of ratio half-periods
    // pairs: the output is low for the first R half-periods and high for the
    // last R, so odd ratios still come out at exactly 50% duty.
    function automatic logic [1:0] ddr_pattern(input logic [CMP_W-1:0] cnt,
                                               input logic [CMP_W-1:0] ratio);
        logic [CMP_W-1:0] twice;
        logic             hi0;
        logic             hi1;
        twice = {cnt[CMP_W-2:0], 1'b0};
        hi0   = (twice >= ratio);
        // twice is even, so OR-ing in bit 0 is the +1 for the low-phase slot
        hi1   = ((twice | CMP_W'(1)) >= ratio);
        return {hi1, hi0};
    endfunction

endpackage

// File: rtl/clkgen_chan.sv
// rtl/clkgen_chan.sv - one divided-clock channel: counter, ratio, pending write, run FSM
//
// Purpose: generates the DDR pair, clock enable and toggle for one channel.
// Ports:
//   clk_i      in   FSBCLK
//   rst_i      in   synchronous active-high reset
//   run_i      in   level, 1 = run, 0 = stop at next boundary
//   sync_i     in   pulse, restart the period now and apply any pending ratio
//   wr_i       in   ratio write strobe already decoded for this channel
//   wr_div_i   in   DIV value for the write
//   busy_o     out  a written ratio is waiting for the next boundary
//   stopped_o  out  channel parked
//   d0_o/d1_o  out  level for FSBCLK high/low phase
//   ce_o       out  one-cycle pulse on the last cycle of each period
//   tog_o      out  toggles on every ce_o
// DW must not exceed clkgen_pkg::DW_MAX.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    input  logic          sync_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_div_i,
    output logic          busy_o,
    output logic          stopped_o,
    output logic          d0_o,
    output logic          d1_o,
    output logic          ce_o,
    output logic          tog_o
);

    chan_state_t   state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          d0_q, d0_d;
    logic          d1_q, d1_d;
    logic          ce_q, ce_d;
    logic          tog_q, tog_d;
    logic          stopped_q, stopped_d;

    logic          boundary;
    logic          run_d;
    logic [1:0]    pat;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        boundary = (cnt_q == div_q);

        case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                // A write that hit the stopping boundary is still pending here
                if (busy_q) begin
                    div_d  = pend_q;
                    busy_d = 1'b0;
                end
                if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_STOPPING: begin
                // SYNC behaves as an early boundary: same restart, same ratio swap
                if (sync_i || boundary) begin
                    cnt_d = '0;
                    if (busy_q) begin
                        div_d  = pend_q;
                        busy_d = 1'b0;
                    end
                    state_d = run_i ? ST_RUN : ST_STOPPED;
                end else begin
                    cnt_d   = cnt_q + DW'(1);
                    state_d = run_i ? ST_RUN : ST_STOPPING;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_STOPPED;
            end
        endcase

        // A new write is taken after any swap above, so a write on a boundary
        // waits for the following one and a write while busy overwrites.
        if (wr_i) begin
            if (state_q == ST_STOPPED) begin
                div_d  = wr_div_i;
                busy_d = 1'b0;
            end else begin
                pend_d = wr_div_i;
                busy_d = 1'b1;
            end
        end

        // Outputs are registered from the next state so they line up with cnt_q
        run_d     = (state_d != ST_STOPPED);
        pat       = ddr_pattern(CMP_W'(cnt_d), CMP_W'(div_d) + CMP_W'(1));
        d0_d      = run_d & pat[0];
        d1_d      = run_d & pat[1];
        ce_d      = run_d && (cnt_d == div_d);
        tog_d     = tog_q ^ ce_q;
        stopped_d = !run_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            div_q     <= DW'(RESET_DIV);
            pend_q    <= '0;
            busy_q    <= 1'b0;
            d0_q      <= 1'b0;
            d1_q      <= 1'b0;
            ce_q      <= 1'b0;
            tog_q     <= 1'b0;
            stopped_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            ce_q      <= ce_d;
            tog_q     <= tog_d;
            stopped_q <= stopped_d;
        end
    end

    assign busy_o    = busy_q;
    assign stopped_o = stopped_q;
    assign d0_o      = d0_q;
    assign d1_o      = d1_q;
    assign ce_o      = ce_q;
    assign tog_o     = tog_q;

endmodule

// File: rtl/clkgen_divmux.sv
// rtl/clkgen_divmux.sv - multi-channel programmable clock-pattern generator (FSBCLK domain)
//
// Purpose: NCH independent divided clocks as DDR pairs for ODDR2 forwarding,
// with clock enables, toggles, glitch-free ratio updates and common SYNC.
// Ports:
//   FSBCLK    in   sole clock
//   RESET     in   synchronous active-high reset
//   CFG_WE    in   ratio write strobe
//   CFG_CH    in   target channel, writes to channels >= NCH are dropped
//   CFG_DIV   in   new DIV (ratio = DIV+1)
//   CFG_BUSY  out  per channel: ratio write pending
//   RUN       in   per channel run level
//   STOPPED   out  per channel parked
//   SYNC      in   realign all running channels
//   D0/D1     out  per channel DDR data pair
//   CE        out  per channel end-of-period pulse
//   TOG       out  per channel toggle on CE
module clkgen_divmux
    import clkgen_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int DW        = DW_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           FSBCLK,
    input  logic           RESET,
    input  logic           CFG_WE,
    input  logic [CHW-1:0] CFG_CH,
    input  logic [DW-1:0]  CFG_DIV,
    output logic [NCH-1:0] CFG_BUSY,
    input  logic [NCH-1:0] RUN,
    output logic [NCH-1:0] STOPPED,
    input  logic           SYNC,
    output logic [NCH-1:0] D0,
    output logic [NCH-1:0] D1,
    output logic [NCH-1:0] CE,
    output logic [NCH-1:0] TOG
);

    logic [NCH-1:0] wr_sel;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign wr_sel[i] = CFG_WE && (CFG_CH == CHW'(i));

        clkgen_chan #(
            .DW        (DW),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk_i     (FSBCLK),
            .rst_i     (RESET),
            .run_i     (RUN[i]),
            .sync_i    (SYNC),
            .wr_i      (wr_sel[i]),
            .wr_div_i  (CFG_DIV),
            .busy_o    (CFG_BUSY[i]),
            .stopped_o (STOPPED[i]),
            .d0_o      (D0[i]),
            .d1_o      (D1[i]),
            .ce_o      (CE[i]),
            .tog_o     (TOG[i])
        );
    end

endmodule

// File: tb/tb_clkgen_divmux.sv
// tb/tb_clkgen_divmux.sv - scoreboard bench for clkgen_divmux
module tb_clkgen_divmux;

    logic       FSBCLK = 1'b0;
    logic       RESET;
    logic       CFG_WE;
    logic [1:0] CFG_CH;
    logic [3:0] CFG_DIV;
    logic [3:0] RUN;
    logic       SYNC;
    logic [3:0] CFG_BUSY, STOPPED, D0, D1, CE, TOG;

    clkgen_divmux #(.NCH(4), .DW(4), .RESET_DIV(1)) dut (
        .FSBCLK   (FSBCLK),
        .RESET    (RESET),
        .CFG_WE   (CFG_WE),
        .CFG_CH   (CFG_CH),
        .CFG_DIV  (CFG_DIV),
        .CFG_BUSY (CFG_BUSY),
        .RUN      (RUN),
        .STOPPED  (STOPPED),
        .SYNC     (SYNC),
        .D0       (D0),
        .D1       (D1),
        .CE       (CE),
        .TOG      (TOG)
    );

    always #5 FSBCLK = ~FSBCLK;

    // Observed word nibbles: D0 D1 CE TOG STOPPED BUSY
    typedef struct {
        int          cyc;
        string       tag;
        logic [23:0] exp;
        logic [23:0] msk;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ent;
    logic [23:0] act;
    int          cyc       = 0;
    int          checks    = 0;
    int          errors    = 0;
    bit          finishing = 1'b0;
    logic [3:0]  p, t;
    // ch2 stop/restart, {d0,d1,ce,stopped}
    logic [3:0]  stop_tbl [9] = '{4'b0000, 4'b0000, 4'b1100, 4'b1110, 4'b0001,
                                  4'b0001, 4'b0000, 4'b0000, 4'b1100};

    initial forever begin
        @(posedge FSBCLK);
        cyc++;
    end

    task automatic tick();
        @(posedge FSBCLK);
        #1;
    endtask

    task automatic push_all(input string tag, input logic [23:0] exp);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.exp = exp; e.msk = '1;
        sbq.push_back(e);
    endtask

    task automatic push_ch(input string tag, input int ch,
                           input bit d0, input bit d1, input bit ce,
                           input bit stp, input bit bsy);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.exp = '0; e.msk = '0;
        e.exp[20+ch] = d0;  e.msk[20+ch] = 1'b1;
        e.exp[16+ch] = d1;  e.msk[16+ch] = 1'b1;
        e.exp[12+ch] = ce;  e.msk[12+ch] = 1'b1;
        e.exp[4+ch]  = stp; e.msk[4+ch]  = 1'b1;
        e.exp[ch]    = bsy; e.msk[ch]    = 1'b1;
        sbq.push_back(e);
    endtask

    task automatic push_tog(input string tag, input int ch, input bit tg);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.exp = '0; e.msk = '0;
        e.exp[8+ch] = tg; e.msk[8+ch] = 1'b1;
        sbq.push_back(e);
    endtask

    task automatic wr(input int ch, input int div);
        CFG_WE  = 1'b1;
        CFG_CH  = 2'(ch);
        CFG_DIV = 4'(div);
    endtask

    // Monitor: compares every entry scheduled for the current cycle
    initial forever begin
        @(negedge FSBCLK);
        act = {D0, D1, CE, TOG, STOPPED, CFG_BUSY};
        while (sbq.size() > 0 && (finishing || sbq[0].cyc <= cyc)) begin
            ent = sbq.pop_front();
            checks++;
            if (ent.cyc != cyc) begin
                errors++;
                $display("FAIL %s not observed: scheduled cycle %0d, now cycle %0d",
                         ent.tag, ent.cyc, cyc);
            end else if ((act & ent.msk) != (ent.exp & ent.msk)) begin
                errors++;
                $display("FAIL %s cycle %0d actual %h required %h (mask %h)",
                         ent.tag, cyc, act & ent.msk, ent.exp & ent.msk, ent.msk);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0; RUN = '0; SYNC = 1'b0;
        tick(); tick();
        push_all("reset", 24'h00_00_f0);
        RESET = 1'b0;
        RUN   = 4'hf;

        // all channels R=2
        for (int j = 0; j < 4; j++) begin
            tick();
            p = (j % 2 == 1) ? 4'hf : 4'h0;
            t = ((j / 2) % 2 == 1) ? 4'hf : 4'h0;
            push_all($sformatf("run_r2_%0d", j), {p, p, p, t, 4'h0, 4'h0});
        end

        // ch0 -> R=3 written mid-period
        tick();
        push_ch("cfg0_pre", 0, 0, 0, 0, 0, 0);
        wr(0, 2);
        tick();
        CFG_WE = 1'b0;
        push_ch("cfg0_busy", 0, 1, 1, 1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            push_ch($sformatf("r3_%0d", k), 0, k % 3 == 2, k % 3 != 0, k % 3 == 2, 0, 0);
        end

        // ch1 -> R=1
        tick();
        push_ch("cfg1_pre", 1, 0, 0, 0, 0, 0);
        wr(1, 0);
        tick();
        CFG_WE = 1'b0;
        push_ch("cfg1_busy", 1, 1, 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            push_ch($sformatf("r1_%0d", k), 1, 0, 1, 1, 0, 0);
            push_tog($sformatf("r1_tog_%0d", k), 1, k % 2 == 0);
        end

        // ch2 -> R=4, then stop at cnt=0 and restart
        tick();
        wr(2, 3);
        tick();
        CFG_WE = 1'b0;
        push_ch("cfg2_busy", 2, 1, 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            push_ch($sformatf("r4_%0d", k), 2, k >= 2, k >= 2, k == 3, 0, 0);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) RUN = 4'b1011;
            if (k == 5) RUN = 4'hf;
            push_ch($sformatf("stop2_%0d", k), 2, stop_tbl[k][3], stop_tbl[k][2],
                    stop_tbl[k][1], stop_tbl[k][0], 0);
            if (k == 3) push_tog("stop2_tog_run", 2, 1'b1);
            if (k == 5) push_tog("stop2_tog_held", 2, 1'b0);
        end

        // ch3: write on a boundary waits a period, then R=4 -> pending R=5 applied by SYNC
        tick();
        push_ch("b3_at_bnd", 3, 1, 1, 1, 0, 0);
        wr(3, 3);
        tick();
        CFG_WE = 1'b0;
        push_ch("b3_pend", 3, 0, 0, 0, 0, 1);
        tick();
        push_ch("b3_pend2", 3, 1, 1, 1, 0, 1);
        tick();
        push_ch("b3_app", 3, 0, 0, 0, 0, 0);
        tick();
        push_ch("r4_ch3", 3, 0, 0, 0, 0, 0);
        wr(3, 4);
        tick();
        CFG_WE = 1'b0;
        push_ch("sync_pre3", 3, 1, 1, 0, 0, 1);
        push_ch("sync_bnd0", 0, 1, 1, 1, 0, 0);
        SYNC = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            SYNC = 1'b0;
            push_ch($sformatf("sync0_%0d", k), 0, k % 3 >= 2, k % 3 >= 1, k % 3 == 2, 0, 0);
            push_ch($sformatf("sync3_%0d", k), 3, k % 5 >= 3, k % 5 >= 2, k % 5 == 4, 0, 0);
        end

        // reset mid-period with a pending write on ch0
        tick();
        wr(0, 5);
        tick();
        CFG_WE = 1'b0;
        push_ch("rst_pre", 0, 0, 1, 0, 0, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        push_all("rst_mid", 24'h00_00_f0);
        tick();
        push_all("rst_run0", 24'h00_00_00);
        tick();
        push_all("rst_run1", 24'hff_f0_00);
        tick();
        push_all("rst_run2", 24'h00_0f_00);

        tick();
        finishing = 1'b1;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
